// File: rtl/game_pkg.sv
// Shared types and default timing constants for the game flow controller.
package game_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int unsigned DEF_JUMP_COOLDOWN = 20;
  localparam int unsigned DEF_GAMEOVER_HOLD = 60;

endpackage

// File: rtl/key_edge_detect.sv
// Turns a key level into a one-cycle press pulse. The previous-level register
// resets high so a key held through reset must be released before it counts.
module key_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic press_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= level_i;
  end

  assign press_o = level_i & ~prev_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game state sequencing (menu/run/pause/over) and jump request arbitration
// with a frame-counted cooldown after each acknowledged jump.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned JUMP_COOLDOWN = DEF_JUMP_COOLDOWN,
  parameter int unsigned GAMEOVER_HOLD = DEF_GAMEOVER_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       space,
  input  logic       enter,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       jump_ack,
  output logic       jump_req,
  output logic [1:0] state,
  output logic       run_en,
  output logic       game_rst
);

  localparam int unsigned CW = $clog2(JUMP_COOLDOWN + 1);
  localparam int unsigned HW = $clog2(GAMEOVER_HOLD + 1);

  game_state_t   state_q, state_d;
  logic          jump_req_q, jump_req_d;
  logic          game_rst_q, game_rst_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          space_press, enter_press;

  key_edge_detect u_space_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (space),
    .press_o (space_press)
  );

  key_edge_detect u_enter_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (enter),
    .press_o (enter_press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= MENU;
      jump_req_q <= 1'b0;
      game_rst_q <= 1'b0;
      cool_q     <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      jump_req_q <= jump_req_d;
      game_rst_q <= game_rst_d;
      cool_q     <= cool_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    jump_req_d = jump_req_q;
    game_rst_d = 1'b0;
    cool_d     = cool_q;
    hold_d     = hold_q;

    case (state_q)
      MENU: begin
        cool_d = '0;
        if (enter_press) begin
          state_d    = RUN;
          game_rst_d = 1'b1;
        end
      end

      RUN: begin
        if (frame_tick && cool_q != '0) cool_d = cool_q - 1'b1;
        // Collision outranks enter, which outranks the jump handshake; leaving
        // RUN drops any pending request without loading the cooldown.
        if (collision) begin
          state_d    = OVER;
          hold_d     = HW'(GAMEOVER_HOLD);
          jump_req_d = 1'b0;
          cool_d     = '0;
        end else if (enter_press) begin
          state_d    = PAUSE;
          jump_req_d = 1'b0;
        end else if (jump_req_q && jump_ack) begin
          jump_req_d = 1'b0;
          cool_d     = CW'(JUMP_COOLDOWN);
        end else if (!jump_req_q && cool_q == '0 && space_press) begin
          jump_req_d = 1'b1;
        end
      end

      PAUSE: begin
        if (enter_press) state_d = RUN;
      end

      OVER: begin
        if (frame_tick && hold_q != '0) hold_d = hold_q - 1'b1;
        if (enter_press && hold_q == '0) state_d = MENU;
      end

      default: state_d = MENU;
    endcase
  end

  assign state    = state_q;
  assign run_en   = (state_q == RUN);
  assign jump_req = jump_req_q;
  assign game_rst = game_rst_q;

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Sequences the game from the decoded keyboard levels (space, enter): menu, run, pause and game-over flow.
- Arbitrates jump requests to the player module through a req/ack handshake with a frame-based cooldown.
- Sits between the keyboard decode block and the game-object/render logic.
- Consumes a per-frame tick from the VGA timing chain and a collision flag from game logic.

Parameters:
- JUMP_COOLDOWN, 20, frames after an acknowledged jump during which space presses are ignored; must be >= 1.
- GAMEOVER_HOLD, 60, frames after entering OVER during which enter presses are ignored; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- space  input  1  space key level (1 = held), from the keyboard decode block.
- enter  input  1  enter key level (1 = held).
- frame_tick  input  1  one-cycle pulse per video frame.
- collision  input  1  player/obstacle collision; honoured only in RUN.
- jump_ack  input  1  player module accepts the pending jump.
- jump_req  output  1  jump request, held until acknowledged.
- state  output  2  current game_state_t.
- run_en  output  1  high while state == RUN.
- game_rst  output  1  one-cycle pulse: reinitialise game objects.

Behaviour:
- Single clock domain (clk).
- Reset: on rst_n low at a clk edge:
  - state = MENU; jump_req = 0; game_rst = 0; run_en = 0.
  - Cooldown and hold counters = 0.
  - Key-previous registers = 1, so a key held through reset is not a press until released and pressed again.
- Press detection: press = level & ~prev, with prev registered every cycle. One press per physical press; auto-repeat of a held key never re-triggers.
- Latency: a press sampled at edge k updates state, jump_req and game_rst at edge k+1 (all outputs registered).
- FSM:
  - MENU, enter press -> RUN; pulse game_rst for exactly one cycle, coincident with the first RUN cycle.
  - RUN, collision -> OVER; load hold counter = GAMEOVER_HOLD.
  - RUN, enter press -> PAUSE.
  - PAUSE, enter press -> RUN (no game_rst).
  - OVER, enter press with hold counter == 0 -> MENU.
  - All other inputs: remain in the current state.
- Priority in RUN: collision > enter press > space press. On collision plus enter in the same cycle, the result is OVER.
- Hold counter: decrements on frame_tick while in OVER and > 0. Enter presses while nonzero are discarded, not queued.
- Jump handshake:
  - In RUN, a space press with jump_req == 0 and cooldown == 0 sets jump_req.
  - jump_req stays high until jump_ack is sampled high; it clears the next cycle, and cooldown loads JUMP_COOLDOWN at the same time.
  - jump_ack while jump_req == 0 is ignored.
  - Space presses during pending jump_req or cooldown > 0 are discarded.
- Cooldown counter:
  - Decrements on frame_tick only in RUN; frozen in PAUSE.
  - Cleared to 0 on entering MENU or OVER.
- Leaving RUN (to PAUSE or OVER) clears jump_req the same edge. A jump_ack arriving then is ignored and does not load cooldown.
- jump_ack and collision in the same RUN cycle: OVER wins; jump_req clears; cooldown = 0.
- Counter widths: $clog2(PARAM+1). Counters saturate at 0 and never wrap.
- run_en and state are derived from the state register, so there are no extra-cycle skews between them.

Decomposition:
- Shared package game_pkg:
  - typedef enum logic [1:0] game_state_t: MENU = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3.
  - Default cooldown and hold constants.
- Sub-module key_edge_detect: level in, one-cycle press out, prev register reset to 1. Instantiated twice (space, enter).

Test Plan:
- Reset with enter held high, release, press once -> state stays MENU until the press; then state = RUN, game_rst high exactly 1 cycle, run_en = 1.
- RUN, space press, jump_ack asserted 3 cycles later -> jump_req high for 3 cycles then 0; space presses over the next 19 frame_ticks ignored; a press after the 20th tick raises jump_req.
- RUN, space held for 100 cycles -> exactly one jump_req assertion.
- RUN, collision and enter press in the same cycle -> state = OVER, not PAUSE; jump_req = 0.
- OVER, enter pressed after 30 frame_ticks -> stays OVER; enter pressed after the 60th tick -> state = MENU, game_rst stays 0.
- RUN, pause with cooldown = 5, 10 frame_ticks in PAUSE, resume -> cooldown still 5; rst_n low mid-RUN with jump_req high -> next cycle state = MENU, jump_req = 0, run_en = 0.
